activation_unit: RTL

ACTIVATION_UNIT -- requirements
Module: activation_unit

---
 rtl/act_pkg.sv | 14 +
 rtl/act_lane.sv | 58 +++++
 rtl/activation_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared definitions for the activation unit: mode encodings and fixed widths.
package act_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned SHIFT_W = 5;

  typedef enum logic [MODE_W-1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// Single-lane activation function, purely combinational.
// Optional feature macro: ACT_LEAKY_EN (leaky mode; otherwise mode 3 behaves as ReLU).
// Ports:
//   i_mode       activation select
//   i_x          signed input element
//   i_clip_max   clip upper bound (negative bound clamps to zero)
//   i_leak_shift negative-slope shift for leaky mode
//   o_y_c        activated element
//   o_zero_c     input was negative and output is zero
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  act_mode_e                      i_mode,
  input  logic signed [DATA_WIDTH-1:0]   i_x,
  input  logic signed [DATA_WIDTH-1:0]   i_clip_max,
  input  logic        [SHIFT_W-1:0]      i_leak_shift,
  output logic signed [DATA_WIDTH-1:0]   o_y_c,
  output logic                           o_zero_c
);

  logic                         w_neg;
  logic signed [DATA_WIDTH-1:0] w_clip_hi;

  assign w_neg     = i_x[DATA_WIDTH-1];
  assign w_clip_hi = i_clip_max[DATA_WIDTH-1] ? '0 : i_clip_max;

`ifndef ACT_LEAKY_EN
  logic w_unused_shift;
  assign w_unused_shift = ^i_leak_shift;
`endif

  // Element function selected by mode
  always_comb begin
    o_y_c = i_x;
    unique case (i_mode)
      ACT_BYPASS: o_y_c = i_x;
      ACT_RELU:   if (w_neg) o_y_c = '0;
      ACT_CLIP: begin
        if (w_neg)                 o_y_c = '0;
        else if (i_x > w_clip_hi)  o_y_c = w_clip_hi;
      end
      ACT_LEAKY: begin
`ifdef ACT_LEAKY_EN
        if (w_neg) o_y_c = i_x >>> i_leak_shift;
`else
        if (w_neg) o_y_c = '0;
`endif
      end
      default: o_y_c = i_x;
    endcase
  end

  // A negative leaky result is never zero, so this flag only fires for forced zeros
  assign o_zero_c = w_neg && (o_y_c == '0);

endmodule

// File: rtl/activation_unit.sv
// Two-stage valid/ready activation pipeline over LANES signed elements, with a
// saturating count of lanes forced to zero.
// Optional feature macro: ACT_LEAKY_EN (enables leaky mode 3; otherwise mode 3 = ReLU
// and leak_shift is ignored).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mode, clip_max, leak_shift per-beat configuration, sampled with the input beat
//   in_valid/in_ready/in_data  input beat stream
//   out_valid/out_ready/out_data output beat stream
//   cnt_clr, zero_cnt          synchronous counter clear, forced-zero lane count
module activation_unit
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MODE_W-1:0]             mode,
  input  logic [DATA_WIDTH-1:0]         clip_max,
  input  logic [SHIFT_W-1:0]            leak_shift,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  input  logic                          cnt_clr,
  output logic [CNT_WIDTH-1:0]          zero_cnt
);

  localparam int unsigned BUS_W = LANES * DATA_WIDTH;
  localparam int unsigned ZW    = $clog2(LANES + 1);
  localparam int unsigned SUM_W = CNT_WIDTH + 1;

  logic                  r_s1_valid;
  logic [BUS_W-1:0]      r_s1_data;
  act_mode_e             r_s1_mode;
  logic [DATA_WIDTH-1:0] r_s1_clip;
  logic [SHIFT_W-1:0]    w_s1_shift;

  logic                  r_out_valid;
  logic [BUS_W-1:0]      r_out_data;
  logic [ZW-1:0]         r_out_zeros;
  logic [CNT_WIDTH-1:0]  r_zero_cnt;

  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic [BUS_W-1:0]      w_y;
  logic [LANES-1:0]      w_zero;
  logic [ZW-1:0]         w_zero_sum;
  logic [SUM_W-1:0]      w_cnt_sum;
  logic [CNT_WIDTH-1:0]  w_cnt_next;

  // Output stage moves when empty or draining; stage 1 also fills when it is a bubble
  assign w_s2_adv  = !r_out_valid || out_ready;
  assign w_s1_adv  = w_s2_adv || !r_s1_valid;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign zero_cnt  = r_zero_cnt;

  // Stage 1: capture beat and its configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= ACT_BYPASS;
      r_s1_clip  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_mode <= act_mode_e'(mode);
        r_s1_clip <= clip_max;
      end
    end
  end

`ifdef ACT_LEAKY_EN
  logic [SHIFT_W-1:0] r_s1_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_s1_shift <= '0;
    else if (w_s1_adv && in_valid)   r_s1_shift <= leak_shift;
  end

  assign w_s1_shift = r_s1_shift;
`else
  logic w_unused_shift;
  assign w_unused_shift = ^leak_shift;
  assign w_s1_shift     = SHIFT_W'(0);
`endif

  // Per-lane element function
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    act_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .i_mode       (r_s1_mode),
      .i_x          (r_s1_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .i_clip_max   (r_s1_clip),
      .i_leak_shift (w_s1_shift),
      .o_y_c        (w_y[gi*DATA_WIDTH +: DATA_WIDTH]),
      .o_zero_c     (w_zero[gi])
    );
  end

  // Number of forced-zero lanes in the stage-1 beat
  always_comb begin
    w_zero_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_zero_sum = w_zero_sum + ZW'(w_zero[i]);
    end
  end

  // Stage 2: registered output, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zeros <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_y;
        r_out_zeros <= w_zero_sum;
      end
    end
  end

  // Saturating add: carry out of the counter width pins it at all-ones
  assign w_cnt_sum  = {1'b0, r_zero_cnt} + SUM_W'(r_out_zeros);
  assign w_cnt_next = w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];

  // Clear has priority over the handshake increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_zero_cnt <= '0;
    else if (cnt_clr)                   r_zero_cnt <= '0;
    else if (r_out_valid && out_ready)  r_zero_cnt <= w_cnt_next;
  end

endmodule
